// File: rtl/hilo_mul_sequencer_if.sv
// hilo_mul_sequencer_if: request/result bundle between the pipeline and the Hi/Lo sequencer.
// Signals (direction as seen by the sequencer):
//   start_i     request strobe, sampled only while idle
//   op_i        0 MULT, 1 MULTU, 2 MADD, 3 MSUB, 4 MTHI, 5 MTLO, 6 MADDU, 7 MSUBU
//   a_i, b_i    rs / rt operands (a_i is also the MTHI/MTLO source)
//   flush_i     abort the in-flight operation without writing Hi/Lo
//   hilo_read_i decode stage holds an MFHI/MFLO
//   hi_o, lo_o  architectural Hi/Lo
//   busy_o      multiply in flight
//   done_o      one-cycle pulse after a Hi/Lo write
//   stall_o     hilo_read_i & busy_o
interface hilo_mul_sequencer_if;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        flush_i;
   logic        hilo_read_i;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        busy_o;
   logic        done_o;
   logic        stall_o;
   modport master (
      output start_i, op_i, a_i, b_i, flush_i, hilo_read_i,
      input  hi_o, lo_o, busy_o, done_o, stall_o
   );
   modport slave (
      input  start_i, op_i, a_i, b_i, flush_i, hilo_read_i,
      output hi_o, lo_o, busy_o, done_o, stall_o
   );
endinterface

// File: rtl/hilo_mul_sequencer.sv
// hilo_mul_sequencer: iterative shift-add multiply/accumulate owning the Hi/Lo register pair.
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   reset_i  synchronous active-high reset
//   bus      hilo_mul_sequencer_if.slave (request, operands, flush, Hi/Lo, busy/done/stall)
// BITS_PER_CYCLE (1, 2 or 4) multiplier bits are retired per MUL cycle; one FIX cycle
// applies the sign and the accumulate, so a result lands 32/BITS_PER_CYCLE+1 cycles after accept.
module hilo_mul_sequencer #(
   parameter int BITS_PER_CYCLE = 1
) (
   input logic                  clk_i,
   input logic                  reset_i,
   hilo_mul_sequencer_if.slave  bus
);
   localparam int ITER = 32 / BITS_PER_CYCLE;
   typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [31:0] mcand_q, mplier_q, hi_q, lo_q;
   logic [63:0] prod_q;
   logic [2:0]  op_q;
   logic        neg_q, busy_q, done_q;
   logic        sgn;
   logic [31:0] a_abs, b_abs;
   logic [63:0] step, prod_d, p_fix, hilo_d;
   assign sgn    = bus.op_i == 3'd0 || bus.op_i == 3'd2 || bus.op_i == 3'd3;
   // |-2^31| wraps to 0x80000000, which is the correct unsigned magnitude.
   assign a_abs  = (sgn && bus.a_i[31]) ? ~bus.a_i + 32'd1 : bus.a_i;
   assign b_abs  = (sgn && bus.b_i[31]) ? ~bus.b_i + 32'd1 : bus.b_i;
   assign step   = (64'(mcand_q) * 64'(mplier_q[BITS_PER_CYCLE-1:0])) << (cnt_q * BITS_PER_CYCLE);
   assign prod_d = prod_q + step;
   assign p_fix  = neg_q ? ~prod_q + 64'd1 : prod_q;
   assign hilo_d = (op_q == 3'd2 || op_q == 3'd6) ? {hi_q, lo_q} + p_fix :
                   (op_q == 3'd3 || op_q == 3'd7) ? {hi_q, lo_q} - p_fix : p_fix;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start_i && !bus.flush_i) begin
                  if (bus.op_i == 3'd4) begin
                     hi_q   <= bus.a_i;
                     done_q <= 1'b1;
                  end else if (bus.op_i == 3'd5) begin
                     lo_q   <= bus.a_i;
                     done_q <= 1'b1;
                  end else begin
                     mcand_q  <= a_abs;
                     mplier_q <= b_abs;
                     neg_q    <= sgn & (bus.a_i[31] ^ bus.b_i[31]);
                     prod_q   <= '0;
                     op_q     <= bus.op_i;
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= MUL;
                  end
               end
            end
            MUL: begin
               if (bus.flush_i) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  prod_q   <= prod_d;
                  mplier_q <= mplier_q >> BITS_PER_CYCLE;
                  cnt_q    <= cnt_q + 5'd1;
                  if (cnt_q == 5'(ITER - 1)) state_q <= FIX;
               end
            end
            FIX: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
               if (!bus.flush_i) begin
                  {hi_q, lo_q} <= hilo_d;
                  done_q       <= 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
   assign bus.hi_o    = hi_q;
   assign bus.lo_o    = lo_q;
   assign bus.busy_o  = busy_q;
   assign bus.done_o  = done_q;
   assign bus.stall_o = bus.hilo_read_i & busy_q;
endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// tb_hilo_mul_sequencer: directed scoreboard bench for two sequencer widths (1 and 4 bits/cycle).
module tb_hilo_mul_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   hilo_mul_sequencer_if b1 ();
   hilo_mul_sequencer_if b4 ();
   hilo_mul_sequencer #(.BITS_PER_CYCLE(1)) d1 (.clk_i(clk), .reset_i(rst), .bus(b1.slave));
   hilo_mul_sequencer #(.BITS_PER_CYCLE(4)) d4 (.clk_i(clk), .reset_i(rst), .bus(b4.slave));
   int checks = 0;
   int failures = 0;
   logic [63:0] q1[$];
   logic [63:0] q4[$];
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (b1.done_o === 1'b1) begin
         if (q1.size() == 0) check("done1_unexpected", {63'b0, b1.done_o}, 64'd0);
         else check("hilo1", {b1.hi_o, b1.lo_o}, q1.pop_front());
      end
      if (b4.done_o === 1'b1) begin
         if (q4.size() == 0) check("done4_unexpected", {63'b0, b4.done_o}, 64'd0);
         else check("hilo4", {b4.hi_o, b4.lo_o}, q4.pop_front());
      end
   end
   task automatic drive(input bit w, input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (w) begin
         b4.start_i = s; b4.op_i = op; b4.a_i = a; b4.b_i = b;
      end else begin
         b1.start_i = s; b1.op_i = op; b1.a_i = a; b1.b_i = b;
      end
   endtask
   // Issue one request, scramble the operands after the accept edge, wait for Done.
   task automatic run(input bit w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] e, input int ebusy, input bit chain);
      int nb;
      bit got;
      drive(w, 1'b1, op, a, b);
      @(posedge clk);
      #1 drive(w, 1'b0, op, 32'hA5A5_5A5A, 32'h5A5A_A5A5);
      if (w) q4.push_back(e); else q1.push_back(e);
      nb = 0;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (w ? b4.busy_o : b1.busy_o) nb++;
         if (w ? b4.done_o : b1.done_o) got = 1;
      end
      check(w ? "done4_seen" : "done1_seen", {63'b0, got}, 64'd1);
      check(w ? "busy4_cycles" : "busy1_cycles", 64'(nb), 64'(ebusy));
      if (!chain) begin
         @(negedge clk);
         check(w ? "done4_pulse" : "done1_pulse", {63'b0, w ? b4.done_o : b1.done_o}, 64'd0);
      end
   endtask
   initial begin
      #300000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end
   initial begin
      int nb, ns;
      bit got;
      drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
      drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
      b1.flush_i = 0; b1.hilo_read_i = 0;
      b4.flush_i = 0; b4.hilo_read_i = 0;
      repeat (2) @(negedge clk);
      check("rst_hilo1", {b1.hi_o, b1.lo_o}, 64'd0);
      check("rst_flags1", {62'b0, b1.busy_o, b1.done_o}, 64'd0);
      check("rst_hilo4", {b4.hi_o, b4.lo_o}, 64'd0);
      rst = 0;
      fork
         begin
            run(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 0);
            run(0, 3'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, 0);
            run(0, 3'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 33, 0);
            run(0, 3'd4, 32'd0, 32'd0, 64'h0000_0000_FFFF_FFEB, 0, 0);
            run(0, 3'd5, 32'd5, 32'd0, 64'h0000_0000_0000_0005, 0, 0);
            run(0, 3'd2, 32'd2, 32'd3, 64'h0000_0000_0000_000B, 33, 0);
            run(0, 3'd3, 32'd4, 32'd4, 64'hFFFF_FFFF_FFFF_FFFB, 33, 0);
            b1.hilo_read_i = 1;
            drive(0, 1'b1, 3'd1, 32'd10, 32'd10);
            @(posedge clk);
            #1 drive(0, 1'b0, 3'd1, 32'd0, 32'd0);
            q1.push_back(64'd100);
            nb = 0; ns = 0; got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
               @(negedge clk);
               if (i == 4) drive(0, 1'b1, 3'd1, 32'd1, 32'd1);
               else b1.start_i = 0;
               if (b1.busy_o) nb++;
               if (b1.stall_o) ns++;
               if (b1.done_o) got = 1;
            end
            b1.start_i = 0;
            check("repulse_done", {63'b0, got}, 64'd1);
            check("repulse_busy", 64'(nb), 64'd33);
            check("repulse_stall", 64'(ns), 64'd33);
            @(negedge clk);
            check("stall_idle", {63'b0, b1.stall_o}, 64'd0);
            drive(0, 1'b1, 3'd1, 32'd7, 32'd9);
            @(posedge clk);
            #1 b1.start_i = 0;
            repeat (10) @(negedge clk);
            check("flush_busy_before", {63'b0, b1.busy_o}, 64'd1);
            b1.flush_i = 1;
            @(negedge clk);
            check("flush_busy_after", {63'b0, b1.busy_o}, 64'd0);
            b1.flush_i = 0;
            b1.hilo_read_i = 0;
            repeat (40) @(negedge clk);
            check("flush_hilo", {b1.hi_o, b1.lo_o}, 64'd100);
            run(0, 3'd4, 32'h1234_5678, 32'd0, 64'h1234_5678_0000_0064, 0, 0);
            drive(0, 1'b1, 3'd2, 32'd5, 32'd5);
            @(posedge clk);
            #1 b1.start_i = 0;
            repeat (20) @(negedge clk);
            rst = 1;
            @(negedge clk);
            check("midrst_hilo", {b1.hi_o, b1.lo_o}, 64'd0);
            check("midrst_flags", {62'b0, b1.busy_o, b1.done_o}, 64'd0);
            rst = 0;
            run(0, 3'd1, 32'd6, 32'd7, 64'd42, 33, 0);
            run(0, 3'd1, 32'd2, 32'd3, 64'd6, 33, 1);
            run(0, 3'd5, 32'd9, 32'd0, 64'd9, 0, 0);
         end
         begin
            run(1, 3'd5, 32'hFFFF_FFFF, 32'd0, 64'h0000_0000_FFFF_FFFF, 0, 0);
            run(1, 3'd6, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 9, 0);
         end
      join
      check("q1_drained", 64'(q1.size()), 64'd0);
      check("q4_drained", 64'(q4.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hilo_mul_sequencer.md
Name: hilo_mul_sequencer

Overview:
- Multi-cycle multiply/accumulate sequencer that owns the architectural Hi/Lo register pair for the MIPS datapath.
- Runs MULT/MULTU/MADD/MSUB/MADDU/MSUBU as an iterative shift-add over BITS_PER_CYCLE multiplier bits per clock.
- Executes MTHI/MTLO in a single cycle.
- Exports Hi/Lo for MFHI/MFLO and a Stall that holds the pipeline while a Hi/Lo read would hit an in-flight operation.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4. ITER = 32/BITS_PER_CYCLE.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  3  0 MULT, 1 MULTU, 2 MADD, 3 MSUB, 4 MTHI, 5 MTLO, 6 MADDU, 7 MSUBU.
- A  input  32  rs operand; also the MTHI/MTLO source.
- B  input  32  rt operand.
- Flush  input  1  abort the in-flight operation; no Hi/Lo write.
- HiLoRead  input  1  decode stage holds an MFHI/MFLO.
- Hi  output  32  Hi register.
- Lo  output  32  Lo register.
- Busy  output  1  high in MUL and FIX states.
- Done  output  1  one-cycle pulse after a Hi/Lo write.
- Stall  output  1  combinational: HiLoRead & Busy.

Behaviour:
- Reset (sync, active-high): Hi=0, Lo=0, state=IDLE, Busy=0, Done=0, iteration counter=0. Reset wins over Start and Flush. Reset mid-operation discards the operation; no partial write.
- States: IDLE, MUL, FIX.
- IDLE with Flush=1: stay IDLE; Start is dropped.
- IDLE, Start=1, Op=4: Hi<=A at that edge; Done=1 the next cycle; stay IDLE.
- IDLE, Start=1, Op=5: Lo<=A at that edge; Done=1 the next cycle; stay IDLE.
- IDLE, Start=1, multiply Op (0,1,2,3,6,7): at that edge latch the following, then go to MUL with counter=0:
  - mcand = |A| and mplier = |B| for signed ops (0,2,3); raw A and B otherwise.
  - neg = A[31]^B[31] for signed ops; 0 otherwise.
  - 64-bit prod = 0; Op.
  - |-2^31| = 0x80000000 as an unsigned 32-bit value; no overflow.
- MUL: each cycle, prod += (mplier[BITS_PER_CYCLE-1:0] * mcand) << (counter*BITS_PER_CYCLE), computed mod 2^64. Then mplier >>= BITS_PER_CYCLE and counter++. After ITER cycles, go to FIX.
- FIX (one cycle): p = neg ? (~prod+1) : prod. The edge ending FIX writes {Hi,Lo} as follows (all mod 2^64), then returns to IDLE:
  - MULT/MULTU: p.
  - MADD/MADDU: {Hi,Lo}+p.
  - MSUB/MSUBU: {Hi,Lo}-p.
- Done is high exactly one cycle after the FIX write; Busy=0 in that cycle.
- Latency: new Hi/Lo visible ITER+1 cycles after the Start edge (33 at default). Busy is high for exactly ITER+1 cycles.
- Start while Busy: ignored, not queued; Hi/Lo and the operation in flight are unaffected.
- Start in the Done cycle: accepted, since the state is IDLE.
- Flush in MUL or FIX: next edge goes to IDLE; Hi/Lo unchanged; no Done.
- Flush in the same cycle FIX would write: the write is suppressed.
- A and B are sampled only at the accept edge; later changes have no effect.
- Hi and Lo change only at a FIX write, an MTHI/MTLO, or Reset.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 33 cycles; then Hi=0xFFFFFFFE, Lo=0x00000001; Done high 1 cycle.
- MULT A=0x80000000, B=0x80000000 -> Hi=0x40000000, Lo=0x00000000. Then MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- MTHI A=0; MTLO A=5 (each Done next cycle, Busy never high). Then MADD A=2, B=3 -> Hi=0, Lo=0x0000000B. Then MSUB A=4, B=4 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFB.
- MULTU A=10, B=10 with Start re-pulsed (A=1, B=1) at cycle 5 and HiLoRead=1 throughout:
  - Stall=1 while Busy; final Lo=100.
  - Rerun with Flush at cycle 10 -> Hi/Lo keep prior values, no Done, Busy drops next cycle.
- Hi=0x12345678 loaded, MADD started, Reset asserted at cycle 20 -> next cycle Hi=Lo=0, Busy=0, Done=0. Start in the following cycle is accepted normally.
- BITS_PER_CYCLE=4, MADDU with Hi=0, Lo=0xFFFFFFFF, A=1, B=1 -> Busy high 9 cycles; then Hi=0x00000001, Lo=0x00000000.
